// File: rtl/rpn_stack_ctrl.sv
// rpn_stack_ctrl: operand stack and sequencer for the RPN calculator.
// Single-cycle stack commands (PUSH/NEG/DUP/SWAP/CLEAR) run on the accept
// edge. ADD/SUB/MUL pass the top two entries to the external ALU over a
// req/ack handshake, then write the result back.
// Build option: define RPN_STICKY_ERR_EN to make the error flags sticky. They
// then stay set until reset or an accepted CLEAR.
module rpn_stack_ctrl #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [2:0]                 cmd_op,
   input  logic [WIDTH-1:0]           cmd_data,
   output logic                       alu_req,
   output logic [1:0]                 alu_op,
   output logic [WIDTH-1:0]           alu_a,
   output logic [WIDTH-1:0]           alu_b,
   input  logic                       alu_ack,
   input  logic [WIDTH-1:0]           alu_result,
   input  logic                       alu_ovf,
   output logic [WIDTH-1:0]           top,
   output logic [$clog2(DEPTH+1)-1:0] depth,
   output logic                       busy,
   output logic                       err_full,
   output logic                       err_under,
   output logic                       err_ovf
);

   localparam int DW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);
   localparam logic [DW-1:0]    DEPTH_ONE  = DW'(1);
   localparam logic [DW-1:0]    DEPTH_TWO  = DW'(2);
   localparam logic [DW-1:0]    DEPTH_FULL = DW'(DEPTH);
   localparam logic [AW-1:0]    IDX_ONE    = AW'(1);
   localparam logic [WIDTH-1:0] MOST_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef RPN_STICKY_ERR_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   localparam logic [2:0] OP_PUSH  = 3'b000;
   localparam logic [2:0] OP_ADD   = 3'b001;
   localparam logic [2:0] OP_SUB   = 3'b010;
   localparam logic [2:0] OP_MUL   = 3'b011;
   localparam logic [2:0] OP_NEG   = 3'b100;
   localparam logic [2:0] OP_DUP   = 3'b101;
   localparam logic [2:0] OP_SWAP  = 3'b110;
   localparam logic [2:0] OP_CLEAR = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_WRITE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [DW-1:0]    depth_q, depth_d;
   logic [WIDTH-1:0] stack_q [DEPTH];
   logic [WIDTH-1:0] stack_d [DEPTH];
   logic             ready_q, ready_d;
   logic             alu_req_q, alu_req_d;
   logic [1:0]       alu_op_q, alu_op_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             err_full_q, err_full_d;
   logic             err_under_q, err_under_d;
   logic             err_ovf_q, err_ovf_d;

   logic             accept;
   logic [AW-1:0]    top_idx, sec_idx, push_idx;
   logic [WIDTH-1:0] top_val, sec_val;
   logic             has_one, has_two, is_full;

   assign accept   = cmd_valid & ready_q;
   // top_idx wraps when the stack is empty, but it is only used when has_one holds
   assign top_idx  = depth_q[AW-1:0] - IDX_ONE;
   assign sec_idx  = top_idx - IDX_ONE;
   assign push_idx = depth_q[AW-1:0];
   assign top_val  = stack_q[top_idx];
   assign sec_val  = stack_q[sec_idx];
   assign has_one  = (depth_q != '0);
   assign has_two  = (depth_q >= DEPTH_TWO);
   assign is_full  = (depth_q == DEPTH_FULL);

   // Next-state, stack update and error-flag logic for every state
   always_comb begin
      state_d     = state_q;
      depth_d     = depth_q;
      stack_d     = stack_q;
      alu_req_d   = alu_req_q;
      alu_op_d    = alu_op_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      result_d    = result_q;
      err_full_d  = err_full_q;
      err_under_d = err_under_q;
      err_ovf_d   = err_ovf_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               // each accepted command starts from clean flags unless they are sticky
               if (!STICKY) begin
                  err_full_d  = 1'b0;
                  err_under_d = 1'b0;
                  err_ovf_d   = 1'b0;
               end
               case (cmd_op)
                  OP_PUSH: begin
                     if (is_full) begin
                        err_full_d = 1'b1;
                     end else begin
                        stack_d[push_idx] = cmd_data;
                        depth_d           = depth_q + DEPTH_ONE;
                     end
                  end
                  OP_ADD, OP_SUB, OP_MUL: begin
                     if (!has_two) begin
                        err_under_d = 1'b1;
                     end else begin
                        alu_req_d = 1'b1;
                        alu_a_d   = sec_val;
                        alu_b_d   = top_val;
                        alu_op_d  = cmd_op[1:0] - 2'd1;
                        state_d   = S_ISSUE;
                     end
                  end
                  OP_NEG: begin
                     if (!has_one) begin
                        err_under_d = 1'b1;
                     end else begin
                        stack_d[top_idx] = '0 - top_val;
                        // the most negative value has no positive counterpart
                        if (top_val == MOST_NEG) begin
                           err_ovf_d = 1'b1;
                        end
                     end
                  end
                  OP_DUP: begin
                     if (is_full) begin
                        err_full_d = 1'b1;
                     end else if (!has_one) begin
                        err_under_d = 1'b1;
                     end else begin
                        stack_d[push_idx] = top_val;
                        depth_d           = depth_q + DEPTH_ONE;
                     end
                  end
                  OP_SWAP: begin
                     if (!has_two) begin
                        err_under_d = 1'b1;
                     end else begin
                        stack_d[top_idx] = sec_val;
                        stack_d[sec_idx] = top_val;
                     end
                  end
                  default: begin
                     // CLEAR wipes the flags in both flag modes
                     depth_d     = '0;
                     err_full_d  = 1'b0;
                     err_under_d = 1'b0;
                     err_ovf_d   = 1'b0;
                  end
               endcase
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (alu_ack) begin
               alu_req_d = 1'b0;
               result_d  = alu_result;
               err_ovf_d = err_ovf_q | alu_ovf;
               state_d   = S_WRITE;
            end
         end
         default: begin
            // the two operands collapse into the single result
            stack_d[sec_idx] = result_q;
            depth_d          = depth_q - DEPTH_ONE;
            state_d          = S_IDLE;
         end
      endcase

      // ready only once the controller has spent a full cycle back in IDLE
      ready_d = (state_q == S_IDLE) && (state_d == S_IDLE);
   end

   // Control state and registered outputs, with reset overriding every state
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         depth_q     <= '0;
         ready_q     <= 1'b0;
         alu_req_q   <= 1'b0;
         alu_op_q    <= 2'b00;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         result_q    <= '0;
         err_full_q  <= 1'b0;
         err_under_q <= 1'b0;
         err_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         depth_q     <= depth_d;
         ready_q     <= ready_d;
         alu_req_q   <= alu_req_d;
         alu_op_q    <= alu_op_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         result_q    <= result_d;
         err_full_q  <= err_full_d;
         err_under_q <= err_under_d;
         err_ovf_q   <= err_ovf_d;
      end
   end

   // Stack storage; contents are don't-care above depth, so no reset is needed
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stack
         always_ff @(posedge clock) begin
            stack_q[gi] <= stack_d[gi];
         end
      end
   endgenerate

   assign cmd_ready = ready_q;
   assign alu_req   = alu_req_q;
   assign alu_op    = alu_op_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign top       = has_one ? top_val : '0;
   assign depth     = depth_q;
   assign busy      = (state_q != S_IDLE);
   assign err_full  = err_full_q;
   assign err_under = err_under_q;
   assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Directed testbench for rpn_stack_ctrl (WIDTH=8, DEPTH=8). The bench plays
// the CPU side and a hand-driven ALU, then compares each result with a
// value worked out by hand.
module tb_rpn_stack_ctrl;

   localparam logic [2:0] OP_PUSH  = 3'b000;
   localparam logic [2:0] OP_ADD   = 3'b001;
   localparam logic [2:0] OP_SUB   = 3'b010;
   localparam logic [2:0] OP_MUL   = 3'b011;
   localparam logic [2:0] OP_NEG   = 3'b100;
   localparam logic [2:0] OP_DUP   = 3'b101;
   localparam logic [2:0] OP_SWAP  = 3'b110;
   localparam logic [2:0] OP_CLEAR = 3'b111;

`ifdef RPN_STICKY_ERR_EN
   localparam logic STICKY = 1'b1;
`else
   localparam logic STICKY = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [2:0] cmd_op = 3'b000;
   logic [7:0] cmd_data = 8'h00;
   logic       alu_req;
   logic [1:0] alu_op;
   logic [7:0] alu_a, alu_b;
   logic       alu_ack = 1'b0;
   logic [7:0] alu_result = 8'h00;
   logic       alu_ovf = 1'b0;
   logic [7:0] top;
   logic [3:0] depth;
   logic       busy, err_full, err_under, err_ovf;

   int total = 0;
   int bad   = 0;

   rpn_stack_ctrl #(.WIDTH(8), .DEPTH(8)) dut (
      .clock      (clock),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_data   (cmd_data),
      .alu_req    (alu_req),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_ack    (alu_ack),
      .alu_result (alu_result),
      .alu_ovf    (alu_ovf),
      .top        (top),
      .depth      (depth),
      .busy       (busy),
      .err_full   (err_full),
      .err_under  (err_under),
      .err_ovf    (err_ovf)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // wait (bounded) for cmd_ready, sampled on the falling edge
   task automatic wait_ready();
      int n = 0;
      while (cmd_ready !== 1'b1 && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (cmd_ready !== 1'b1) chk("ready_timeout", 32'(cmd_ready), 32'd1);
   endtask

   // issue one command; returns on the falling edge after the accept edge
   task automatic send(input logic [2:0] op, input logic [7:0] data);
      wait_ready();
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      $display("cmd op=%0d data=%0h depth=%0d top=%0h", op, data, depth, top);
      @(negedge clock);
      cmd_valid = 1'b0;
   endtask

   // ALU command with operand check; ack on the first ALU_WAIT cycle
   task automatic run_alu(input logic [2:0] op, input logic [7:0] exp_a, input logic [7:0] exp_b,
                          input logic [7:0] res, input logic ovf);
      send(op, 8'h00);
      chk("issue_req", 32'(alu_req), 32'd1);
      chk("issue_a", 32'(alu_a), 32'(exp_a));
      chk("issue_b", 32'(alu_b), 32'(exp_b));
      chk("issue_op", 32'(alu_op), 32'(op - 3'd1));
      @(negedge clock);
      alu_ack    = 1'b1;
      alu_result = res;
      alu_ovf    = ovf;
      @(negedge clock);
      alu_ack    = 1'b0;
      alu_ovf    = 1'b0;
      $display("alu op=%0d a=%0h b=%0h res=%0h ovf=%0d", op, exp_a, exp_b, res, ovf);
      wait_ready();
   endtask

   initial begin
      // reset held low for two cycles
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("rst_depth", 32'(depth), 32'd0);
      chk("rst_top", 32'(top), 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_req", 32'(alu_req), 32'd0);
      chk("rst_errs", 32'({err_full, err_under, err_ovf}), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);

      // PUSH 5, PUSH 3, SUB with a detailed handshake walk
      send(OP_PUSH, 8'd5);
      send(OP_PUSH, 8'd3);
      chk("push_top", 32'(top), 32'd3);
      chk("push_depth", 32'(depth), 32'd2);
      send(OP_SUB, 8'h00);
      chk("sub_req_issue", 32'(alu_req), 32'd1);
      chk("sub_a", 32'(alu_a), 32'd5);
      chk("sub_b", 32'(alu_b), 32'd3);
      chk("sub_op", 32'(alu_op), 32'd1);
      chk("sub_rdy1", 32'(cmd_ready), 32'd0);
      @(negedge clock);
      chk("sub_req_wait", 32'(alu_req), 32'd1);
      chk("sub_rdy2", 32'(cmd_ready), 32'd0);
      alu_ack    = 1'b1;
      alu_result = 8'd2;
      @(negedge clock);
      alu_ack = 1'b0;
      chk("sub_req_drop", 32'(alu_req), 32'd0);
      chk("sub_busy_wr", 32'(busy), 32'd1);
      chk("sub_rdy3", 32'(cmd_ready), 32'd0);
      @(negedge clock);
      chk("sub_rdy4", 32'(cmd_ready), 32'd0);
      chk("sub_top", 32'(top), 32'd2);
      chk("sub_depth", 32'(depth), 32'd1);
      @(negedge clock);
      chk("sub_rdy5", 32'(cmd_ready), 32'd1);

      // fill to DEPTH, overflow push, then an ALU op
      send(OP_CLEAR, 8'h00);
      chk("clr_depth", 32'(depth), 32'd0);
      chk("clr_top", 32'(top), 32'd0);
      for (int i = 0; i < 8; i++) send(OP_PUSH, 8'(10 + i));
      chk("full_depth", 32'(depth), 32'd8);
      chk("full_top", 32'(top), 32'd17);
      send(OP_PUSH, 8'd9);
      chk("full_err", 32'(err_full), 32'd1);
      chk("full_depth2", 32'(depth), 32'd8);
      chk("full_top2", 32'(top), 32'd17);
      send(OP_DUP, 8'h00);
      chk("dup_full_err", 32'(err_full), 32'd1);
      chk("dup_full_depth", 32'(depth), 32'd8);
      run_alu(OP_ADD, 8'd16, 8'd17, 8'd33, 1'b0);
      chk("add_top", 32'(top), 32'd33);
      chk("add_depth", 32'(depth), 32'd7);
      chk("add_err_full", 32'(err_full), 32'(STICKY));

      // underflow: MUL with one entry
      send(OP_CLEAR, 8'h00);
      send(OP_PUSH, 8'd7);
      send(OP_MUL, 8'h00);
      chk("under_err", 32'(err_under), 32'd1);
      chk("under_req", 32'(alu_req), 32'd0);
      chk("under_busy", 32'(busy), 32'd0);
      @(negedge clock);
      chk("under_req2", 32'(alu_req), 32'd0);
      chk("under_top", 32'(top), 32'd7);
      chk("under_depth", 32'(depth), 32'd1);
      chk("under_ready", 32'(cmd_ready), 32'd1);

      // DUP and SWAP on a small stack
      send(OP_DUP, 8'h00);
      chk("dup_depth", 32'(depth), 32'd2);
      chk("dup_top", 32'(top), 32'd7);
      chk("dup_err_under", 32'(err_under), 32'(STICKY));
      send(OP_PUSH, 8'd1);
      send(OP_SWAP, 8'h00);
      chk("swap_top", 32'(top), 32'd7);
      send(OP_CLEAR, 8'h00);
      send(OP_PUSH, 8'd2);
      send(OP_PUSH, 8'd9);
      send(OP_SWAP, 8'h00);
      chk("swap_top2", 32'(top), 32'd2);
      chk("swap_depth", 32'(depth), 32'd2);

      // NEG boundary cases and empty-stack checks
      send(OP_CLEAR, 8'h00);
      send(OP_NEG, 8'h00);
      chk("neg_empty_under", 32'(err_under), 32'd1);
      send(OP_DUP, 8'h00);
      chk("dup_empty_under", 32'(err_under), 32'd1);
      chk("dup_empty_depth", 32'(depth), 32'd0);
      send(OP_PUSH, 8'h80);
      send(OP_NEG, 8'h00);
      chk("neg_min_top", 32'(top), 32'h80);
      chk("neg_min_ovf", 32'(err_ovf), 32'd1);
      send(OP_PUSH, 8'd5);
      send(OP_NEG, 8'h00);
      chk("neg5_top", 32'(top), 32'hFB);
      chk("neg5_ovf", 32'(err_ovf), 32'(STICKY));

      // ALU overflow: result still written
      send(OP_CLEAR, 8'h00);
      chk("clr_ovf", 32'(err_ovf), 32'd0);
      send(OP_PUSH, 8'd100);
      send(OP_PUSH, 8'd100);
      run_alu(OP_ADD, 8'd100, 8'd100, 8'hC8, 1'b1);
      chk("ovf_top", 32'(top), 32'hC8);
      chk("ovf_err", 32'(err_ovf), 32'd1);
      chk("ovf_depth", 32'(depth), 32'd1);

      // reset in ALU_WAIT, then a stray ack
      send(OP_CLEAR, 8'h00);
      send(OP_PUSH, 8'd1);
      send(OP_PUSH, 8'd2);
      send(OP_MUL, 8'h00);
      chk("mul_op", 32'(alu_op), 32'd2);
      @(negedge clock);
      chk("mul_wait_req", 32'(alu_req), 32'd1);
      reset = 1'b0;
      @(negedge clock);
      chk("mid_rst_req", 32'(alu_req), 32'd0);
      reset = 1'b1;
      @(negedge clock);
      alu_ack    = 1'b1;
      alu_result = 8'd99;
      @(negedge clock);
      alu_ack = 1'b0;
      $display("reset during ALU_WAIT, stray ack sent");
      chk("mid_rst_depth", 32'(depth), 32'd0);
      chk("mid_rst_top", 32'(top), 32'd0);
      chk("mid_rst_req2", 32'(alu_req), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_ready", 32'(cmd_ready), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
